// File: rtl/arb4_rr_32.sv
// arb4_rr_32 -- round-robin arbiter sharing one 32-bit resource among 4 requesters.
// The grant is held for as long as the owner keeps its request high. While the
// grant is held, the owner's data is registered onto sal.
// Every release costs one idle cycle before the next grant is issued.
//
// Optional feature: define ARB_TIMEOUT_EN to add a hold limit. When it is
// enabled, an owner is revoked after MAX_HOLD busy cycles if another requester
// is waiting.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous reset, active-high
//   req    in   4   request per requester, held while the grant is used
//   e1..e4 in   32  data of requesters 0..3
//   gnt    out  4   one-hot grant, zero when idle
//   sel    out  2   index of current owner (mux select), zero when idle
//   sal    out  32  registered data of the owner
//   valid  out  1   sal holds owner data
module arb4_rr_32 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] e1,
  input  logic [31:0] e2,
  input  logic [31:0] e3,
  input  logic [31:0] e4,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic [31:0] sal,
  output logic        valid
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned DW   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   sel_n;
  logic [NREQ-1:0] gnt_n;
  logic [DW-1:0]   sal_n;
  logic            valid_n;
  logic [DW-1:0]   owner_data;
  logic            found;
  logic [IW-1:0]   winner;
  logic            revoke_c;

  // A hold limit of zero has no meaning.
  if (MAX_HOLD == 0) begin : g_bad_hold
    $error("MAX_HOLD must be at least 1");
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold, hold_n;

  // Revoke on the busy cycle that completes MAX_HOLD while someone else waits.
  assign revoke_c = (hold == CW'(MAX_HOLD - 1)) && ((req & ~gnt) != '0);
`else
  assign revoke_c = 1'b0;
`endif

  // Rotating priority: the search starts just after the last owner.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!found && req[ptr + IW'(i)]) begin
        found  = 1'b1;
        winner = ptr + IW'(i);
      end
    end
  end

  // 4:1 data mux driven by the registered select.
  always_comb begin
    case (sel)
      2'd0:    owner_data = e1;
      2'd1:    owner_data = e2;
      2'd2:    owner_data = e3;
      default: owner_data = e4;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = sel;
    sal_n   = sal;
    valid_n = valid;
`ifdef ARB_TIMEOUT_EN
    hold_n  = hold;
`endif
    case (state)
      IDLE: begin
        gnt_n   = '0;
        sel_n   = '0;
        sal_n   = '0;
        valid_n = 1'b0;
        if (found) begin
          state_n = BUSY;
          gnt_n   = NREQ'(1) << winner;
          sel_n   = winner;
          ptr_n   = winner;
`ifdef ARB_TIMEOUT_EN
          hold_n  = '0;
`endif
        end
      end
      BUSY: begin
        // A revocation takes the same path as a release. ptr stays on the old owner.
        if (!req[sel] || revoke_c) begin
          state_n = IDLE;
          gnt_n   = '0;
          sel_n   = '0;
          sal_n   = '0;
          valid_n = 1'b0;
        end else begin
          sal_n   = owner_data;
          valid_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
          if (hold != CW'(MAX_HOLD)) begin
            hold_n = hold + CW'(1);
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= IW'(NREQ - 1);
      gnt   <= '0;
      sel   <= '0;
      sal   <= '0;
      valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold  <= '0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      sal   <= sal_n;
      valid <= valid_n;
`ifdef ARB_TIMEOUT_EN
      hold  <= hold_n;
`endif
    end
  end

endmodule

// File: tb/tb_arb4_rr_32.sv
// tb_arb4_rr_32 -- directed bench for arb4_rr_32.
// A behavioural model tracks owner and priority with plain integers.
// The DUT is compared against that model every cycle.
// Directed sequences also check hand-computed literal values.
module tb_arb4_rr_32;

  localparam int unsigned MAXH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] ed [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [31:0] sal;
  logic        valid;

  int tests = 0;
  int fails = 0;

  arb4_rr_32 #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .e1    (ed[0]),
    .e2    (ed[1]),
    .e3    (ed[2]),
    .e4    (ed[3]),
    .gnt   (gnt),
    .sel   (sel),
    .sal   (sal),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: the owner index (-1 when idle) and the last owner.
  int          m_owner;
  int          m_last;
  int          m_hold;
  logic [31:0] m_sal;
  logic        m_valid;
  bit          started = 1'b0;
  int          cand;
  bit          others;
  logic [3:0]  exp_gnt;
  logic [1:0]  exp_sel;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_last  = 3;
      m_hold  = 0;
      m_sal   = 32'h0;
      m_valid = 1'b0;
      started = 1'b1;
    end else if (m_owner < 0) begin
      m_sal   = 32'h0;
      m_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        cand = (m_last + k) % 4;
        if (m_owner < 0 && req[cand]) begin
          m_owner = cand;
          m_last  = cand;
          m_hold  = 0;
        end
      end
    end else begin
      others = (req & ~(4'b0001 << m_owner)) != 4'b0000;
      if (!req[m_owner] || (TO_EN && m_hold == int'(MAXH) - 1 && others)) begin
        m_owner = -1;
        m_sal   = 32'h0;
        m_valid = 1'b0;
      end else begin
        m_sal   = ed[m_owner];
        m_valid = 1'b1;
        if (m_hold < int'(MAXH)) m_hold++;
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      exp_sel = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      check("model_gnt", 32'(gnt), 32'(exp_gnt));
      check("model_sel", 32'(sel), 32'(exp_sel));
      check("model_sal", sal, m_sal);
      check("model_valid", 32'(valid), 32'(m_valid));
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
    end
  end

  int order [5];
  int n;
  logic [31:0] prev;

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) ed[i] = 32'h0;
    tick(2);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_sel", 32'(sel), 32'h0);
    check("reset_sal", sal, 32'h0);
    check("reset_valid", 32'(valid), 32'h0);

    // Single request: grant after one edge, data after two.
    rst = 1'b0;
    req = 4'b0001;
    ed[0] = 32'hDEADBEEF;
    tick(1);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_sel", 32'(sel), 32'h0);
    check("t1_valid_early", 32'(valid), 32'h0);
    check("t1_model_owner", 32'(m_owner), 32'h0);
    tick(1);
    check("t1_sal", sal, 32'hDEADBEEF);
    check("t1_valid", 32'(valid), 32'h1);
    req = 4'b0000;
    tick(1);
    check("t1_release_gnt", 32'(gnt), 32'h0);
    check("t1_release_valid", 32'(valid), 32'h0);
    tick(1);

    // All requesting; each owner drops three cycles after its grant.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    order = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check("t2_order", 32'(gnt), 32'(4'b0001 << order[i]));
      tick(2);
      req[order[i]] = 1'b0;
      tick(1);
      check("t2_dead", 32'(gnt), 32'h0);
      req[order[i]] = 1'b1;
      tick(1);
    end
    check("t2_next", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick(2);

    // Owner 2 releases, then 0 and 2 are both pending: 0 wins, then 2.
    req = 4'b0100;
    tick(1);
    check("t3_gnt2", 32'(gnt), 32'h4);
    tick(1);
    req = 4'b0001;
    tick(1);
    check("t3_dead", 32'(gnt), 32'h0);
    req = 4'b0101;
    tick(1);
    check("t3_gnt0", 32'(gnt), 32'h1);
    check("t3_model_last", 32'(m_last), 32'h0);
    req = 4'b0100;
    tick(1);
    check("t3_dead2", 32'(gnt), 32'h0);
    tick(1);
    check("t3_gnt2b", 32'(gnt), 32'h4);
    req = 4'b0000;
    tick(2);

    // Reset in the middle of a busy period.
    req = 4'b1111;
    tick(1);
    check("t4_gnt3", 32'(gnt), 32'h8);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("t4_rst_gnt", 32'(gnt), 32'h0);
    check("t4_rst_valid", 32'(valid), 32'h0);
    check("t4_rst_sal", sal, 32'h0);
    rst = 1'b0;
    tick(1);
    check("t4_first_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick(2);

    // Owner data tracked with a one-cycle lag while other inputs change.
    req = 4'b0010;
    tick(1);
    check("t5_gnt1", 32'(gnt), 32'h2);
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) ed[j] = $urandom;
      prev = ed[1];
      tick(1);
      check("t5_track", sal, prev);
    end
    req = 4'b0000;
    tick(2);

    // A second requester arrives while owner 0 holds the grant.
    req = 4'b0001;
    tick(1);
    check("t6_gnt0", 32'(gnt), 32'h1);
    req = 4'b0011;
    n = 0;
    while (gnt == 4'b0001 && n < 12) begin
      n++;
      tick(1);
    end
`ifdef ARB_TIMEOUT_EN
    check("t6_hold_cycles", 32'(n), 32'd4);
    check("t6_revoke_gnt", 32'(gnt), 32'h0);
    tick(1);
    check("t6_gnt1", 32'(gnt), 32'h2);
`else
    check("t6_hold_cycles", 32'(n), 32'd12);
    req = 4'b0010;
    tick(1);
    check("t6_release_gnt", 32'(gnt), 32'h0);
    tick(1);
    check("t6_gnt1", 32'(gnt), 32'h2);
`endif
    req = 4'b0000;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
